// File: rtl/shk_wr_sequencer.sv
// rtl/shk_wr_sequencer.sv - buffered write sequencer driving address/data frames to a shake-to-UART stage
module shk_wr_sequencer #(
    parameter int MD_SIM_ABLE   = 0,
    parameter int NB_BAUD_RATE  = 115200,
    parameter int NB_SYS_FRE    = 100_000_000,
    parameter int WD_SHK_DATA   = 8,
    parameter int WD_SHK_ADDR   = 8,
    parameter int WD_ERR_INFO   = 4,
    parameter int NB_FIFO_DEPTH = 4,
    parameter int NB_TIMEOUT    = 65535
) (
    input  logic                             i_sys_clk,
    input  logic                             i_sys_resetn,
    input  logic                             s_cmd_valid,
    input  logic [WD_SHK_ADDR-1:0]           s_cmd_addr,
    input  logic [WD_SHK_DATA-1:0]           s_cmd_data,
    output logic                             s_cmd_ready,
    output logic                             m_shk_wr_valid,
    output logic                             m_shk_wr_msync,
    output logic [WD_SHK_ADDR-1:0]           m_shk_wr_maddr,
    output logic [WD_SHK_DATA-1:0]           m_shk_wr_mdata,
    input  logic                             m_shk_wr_ready,
    input  logic                             i_err_clr,
    output logic [$clog2(NB_FIFO_DEPTH):0]   o_fifo_level,
    output logic                             o_busy,
    output logic [WD_ERR_INFO-1:0]           m_err_info
);
    // One frame covers start bit, address/data bits, stop bits and a small guard.
    localparam int NB_FRAME = (MD_SIM_ABLE != 0) ? 20
                            : (NB_SYS_FRE / NB_BAUD_RATE) * (WD_SHK_ADDR + 3) + 16;
    localparam int FW = $clog2(NB_FRAME + 1);
    localparam int AW = $clog2(NB_FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(NB_TIMEOUT + 1);
    localparam int EW = WD_SHK_ADDR + WD_SHK_DATA;

    localparam logic [FW-1:0] FRAME_LAST = FW'(NB_FRAME - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(NB_TIMEOUT - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(NB_FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RELEASE} state_t;

    state_t                 state_q, state_d;
    logic [FW-1:0]          frame_cnt_q;
    logic [TW-1:0]          tmo_cnt_q;
    logic [EW-1:0]          mem [NB_FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]          level_q;
    logic [2:0]             err_q;
    logic [WD_SHK_ADDR-1:0] maddr_q;
    logic [WD_SHK_DATA-1:0] mdata_q;

    logic push, pop, push_full, addr_nack, wait_rdy, tmo_hit, fifo_empty;

    assign fifo_empty = (level_q == '0);
    assign s_cmd_ready = (level_q != LEVEL_FULL);
    assign push       = s_cmd_valid && s_cmd_ready;
    assign push_full  = s_cmd_valid && !s_cmd_ready;
    assign wait_rdy   = (state_q == S_IDLE) && !fifo_empty && !m_shk_wr_ready;
    assign tmo_hit    = wait_rdy && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        addr_nack = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && m_shk_wr_ready) begin
                    pop     = 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (frame_cnt_q == FRAME_LAST) begin
                    // Downstream still ready at the end of the address frame means it never took it.
                    addr_nack = m_shk_wr_ready;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (frame_cnt_q == FRAME_LAST) state_d = S_RELEASE;
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || (state_q != S_ADDR && state_q != S_DATA))
                frame_cnt_q <= '0;
            else
                frame_cnt_q <= frame_cnt_q + FW'(1);
            if (!wait_rdy || tmo_hit)
                tmo_cnt_q <= '0;
            else
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (push) mem[wr_ptr_q] <= {s_cmd_addr, s_cmd_data};
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            maddr_q  <= '0;
            mdata_q  <= '0;
            err_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                {maddr_q, mdata_q} <= mem[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            // Clear first, then OR in this cycle's events so a coincident error is kept.
            err_q <= (i_err_clr ? 3'b000 : err_q) | {push_full, addr_nack, tmo_hit};
        end
    end

    assign m_shk_wr_valid = (state_q == S_ADDR) || (state_q == S_DATA);
    assign m_shk_wr_msync = (state_q == S_DATA);
    assign m_shk_wr_maddr = maddr_q;
    assign m_shk_wr_mdata = mdata_q;
    assign o_fifo_level   = level_q;
    assign o_busy         = (state_q != S_IDLE);
    assign m_err_info     = WD_ERR_INFO'(err_q);
endmodule

// File: tb/tb_shk_wr_sequencer.sv
// tb/tb_shk_wr_sequencer.sv - directed self-checking bench for shk_wr_sequencer
module tb_shk_wr_sequencer;
    logic       i_sys_clk = 1'b0;
    logic       i_sys_resetn = 1'b0;
    logic       s_cmd_valid = 1'b0;
    logic [7:0] s_cmd_addr = 8'h00;
    logic [7:0] s_cmd_data = 8'h00;
    logic       s_cmd_ready;
    logic       m_shk_wr_valid;
    logic       m_shk_wr_msync;
    logic [7:0] m_shk_wr_maddr;
    logic [7:0] m_shk_wr_mdata;
    logic       m_shk_wr_ready = 1'b1;
    logic       i_err_clr = 1'b0;
    logic [2:0] o_fifo_level;
    logic       o_busy;
    logic [3:0] m_err_info;

    int n_pass = 0;
    int n_chk  = 0;
    bit rdy_auto = 1'b1;
    bit rdy_manual = 1'b1;

    shk_wr_sequencer #(
        .MD_SIM_ABLE(1), .NB_BAUD_RATE(115200), .NB_SYS_FRE(100_000_000),
        .WD_SHK_DATA(8), .WD_SHK_ADDR(8), .WD_ERR_INFO(4),
        .NB_FIFO_DEPTH(4), .NB_TIMEOUT(100)
    ) dut (
        .i_sys_clk(i_sys_clk), .i_sys_resetn(i_sys_resetn),
        .s_cmd_valid(s_cmd_valid), .s_cmd_addr(s_cmd_addr), .s_cmd_data(s_cmd_data),
        .s_cmd_ready(s_cmd_ready), .m_shk_wr_valid(m_shk_wr_valid),
        .m_shk_wr_msync(m_shk_wr_msync), .m_shk_wr_maddr(m_shk_wr_maddr),
        .m_shk_wr_mdata(m_shk_wr_mdata), .m_shk_wr_ready(m_shk_wr_ready),
        .i_err_clr(i_err_clr), .o_fifo_level(o_fifo_level), .o_busy(o_busy),
        .m_err_info(m_err_info)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    // Downstream model: busy (ready low) only while it is receiving the address frame.
    always @(negedge i_sys_clk)
        m_shk_wr_ready = rdy_auto ? !(m_shk_wr_valid && !m_shk_wr_msync) : rdy_manual;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_sys_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] d);
        s_cmd_valid = 1'b1;
        s_cmd_addr  = a;
        s_cmd_data  = d;
        tick();
        s_cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        i_sys_resetn = 1'b0;
        s_cmd_valid  = 1'b0;
        i_err_clr    = 1'b0;
        tick();
        tick();
        i_sys_resetn = 1'b1;
        tick();
    endtask

    task automatic wait_issue(input logic [7:0] ea, input logic [7:0] ed);
        int n;
        n = 0;
        while (!m_shk_wr_valid && n < 200) begin tick(); n++; end
        n_chk++;
        if (m_shk_wr_valid !== 1'b1 || m_shk_wr_maddr !== ea)
            $display("FAIL issue_addr: valid=%b maddr=%h expected valid=1 maddr=%h", m_shk_wr_valid, m_shk_wr_maddr, ea);
        else n_pass++;
        n = 0;
        while (!m_shk_wr_msync && n < 200) begin tick(); n++; end
        n_chk++;
        if (m_shk_wr_msync !== 1'b1 || m_shk_wr_mdata !== ed)
            $display("FAIL issue_data: msync=%b mdata=%h expected msync=1 mdata=%h", m_shk_wr_msync, m_shk_wr_mdata, ed);
        else n_pass++;
        n = 0;
        while (m_shk_wr_valid && n < 200) begin tick(); n++; end
        n_chk++;
        if (m_shk_wr_valid !== 1'b0)
            $display("FAIL issue_release: valid=%b expected 0", m_shk_wr_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        i_sys_resetn = 1'b0;
        #3;
        n_chk++;
        if ({m_shk_wr_valid, m_shk_wr_msync, s_cmd_ready, o_busy, o_fifo_level, m_err_info, m_shk_wr_maddr, m_shk_wr_mdata}
            !== {1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'h0, 8'h00, 8'h00})
            $display("FAIL reset_state: valid=%b msync=%b rdy=%b busy=%b lvl=%0d err=%h maddr=%h mdata=%h expected 0,0,1,0,0,0,00,00",
                     m_shk_wr_valid, m_shk_wr_msync, s_cmd_ready, o_busy, o_fifo_level, m_err_info, m_shk_wr_maddr, m_shk_wr_mdata);
        else n_pass++;
        tick();
        i_sys_resetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int n;
        rdy_auto = 1'b1;
        tick();
        push(8'h12, 8'hA5);
        n = 1;
        n_chk++;
        if (o_fifo_level !== 3'd1 || m_shk_wr_valid !== 1'b0)
            $display("FAIL single_buffered: lvl=%0d valid=%b expected lvl=1 valid=0", o_fifo_level, m_shk_wr_valid);
        else n_pass++;
        while (!m_shk_wr_valid && n < 10) begin tick(); n++; end
        n_chk++;
        if (n !== 2 || m_shk_wr_maddr !== 8'h12 || o_fifo_level !== 3'd0)
            $display("FAIL single_valid_rise: cycles=%0d maddr=%h lvl=%0d expected 2, 12, 0", n, m_shk_wr_maddr, o_fifo_level);
        else n_pass++;
        n = 0;
        while (!m_shk_wr_msync && n < 50) begin tick(); n++; end
        n_chk++;
        if (n !== 20 || m_shk_wr_mdata !== 8'hA5 || m_shk_wr_valid !== 1'b1)
            $display("FAIL single_msync_rise: cycles=%0d mdata=%h valid=%b expected 20, A5, 1", n, m_shk_wr_mdata, m_shk_wr_valid);
        else n_pass++;
        n = 0;
        while (m_shk_wr_valid && n < 50) begin tick(); n++; end
        n_chk++;
        if (n !== 20 || m_shk_wr_msync !== 1'b0 || o_busy !== 1'b1)
            $display("FAIL single_release: cycles=%0d msync=%b busy=%b expected 20, 0, 1", n, m_shk_wr_msync, o_busy);
        else n_pass++;
        tick();
        n_chk++;
        if (o_busy !== 1'b0 || m_err_info !== 4'h0 || m_shk_wr_maddr !== 8'h12)
            $display("FAIL single_idle: busy=%b err=%h maddr=%h expected 0, 0, 12", o_busy, m_err_info, m_shk_wr_maddr);
        else n_pass++;
    endtask

    task automatic test_full();
        logic [7:0] a, d;
        do_reset();
        rdy_auto = 1'b0;
        rdy_manual = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                n_chk++;
                if (s_cmd_ready !== 1'b0 || o_fifo_level !== 3'd4)
                    $display("FAIL full_ready: rdy=%b lvl=%0d expected 0, 4", s_cmd_ready, o_fifo_level);
                else n_pass++;
            end
            a = 8'h20 + 8'(i);
            d = 8'h30 + 8'(i);
            push(a, d);
        end
        n_chk++;
        if (m_err_info !== 4'h4 || o_fifo_level !== 3'd4 || m_shk_wr_valid !== 1'b0)
            $display("FAIL full_overflow: err=%h lvl=%0d valid=%b expected 4, 4, 0", m_err_info, o_fifo_level, m_shk_wr_valid);
        else n_pass++;
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        n_chk++;
        if (m_err_info !== 4'h0)
            $display("FAIL full_err_clr: err=%h expected 0", m_err_info);
        else n_pass++;
        rdy_auto = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 8'h20 + 8'(i);
            d = 8'h30 + 8'(i);
            wait_issue(a, d);
        end
        repeat (5) tick();
        n_chk++;
        if (o_busy !== 1'b0 || o_fifo_level !== 3'd0 || m_shk_wr_maddr !== 8'h23)
            $display("FAIL full_no_fifth: busy=%b lvl=%0d maddr=%h expected 0, 0, 23", o_busy, o_fifo_level, m_shk_wr_maddr);
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit saw_valid;
        do_reset();
        rdy_auto = 1'b0;
        rdy_manual = 1'b0;
        tick();
        push(8'h44, 8'h55);
        saw_valid = 1'b0;
        repeat (50) begin tick(); saw_valid |= m_shk_wr_valid; end
        n_chk++;
        if (m_err_info !== 4'h0)
            $display("FAIL timeout_early: err=%h expected 0", m_err_info);
        else n_pass++;
        repeat (55) begin tick(); saw_valid |= m_shk_wr_valid; end
        n_chk++;
        if (m_err_info !== 4'h1 || saw_valid !== 1'b0)
            $display("FAIL timeout_flag: err=%h saw_valid=%b expected 1, 0", m_err_info, saw_valid);
        else n_pass++;
        rdy_auto = 1'b1;
        wait_issue(8'h44, 8'h55);
    endtask

    task automatic test_addr_err();
        do_reset();
        rdy_auto = 1'b0;
        rdy_manual = 1'b1;
        tick();
        push(8'h66, 8'h77);
        wait_issue(8'h66, 8'h77);
        n_chk++;
        if (m_err_info !== 4'h2)
            $display("FAIL addr_nack: err=%h expected 2", m_err_info);
        else n_pass++;
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        n_chk++;
        if (m_err_info !== 4'h0)
            $display("FAIL addr_err_clr: err=%h expected 0", m_err_info);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        rdy_auto = 1'b0;
        rdy_manual = 1'b1;
        tick();
        push(8'h81, 8'h82);
        push(8'h83, 8'h84);
        n = 0;
        while (!m_shk_wr_msync && n < 100) begin tick(); n++; end
        repeat (3) tick();
        n_chk++;
        if (m_shk_wr_msync !== 1'b1 || o_fifo_level !== 3'd1 || m_err_info !== 4'h2)
            $display("FAIL midreset_pre: msync=%b lvl=%0d err=%h expected 1, 1, 2", m_shk_wr_msync, o_fifo_level, m_err_info);
        else n_pass++;
        #2;
        i_sys_resetn = 1'b0;
        #1;
        n_chk++;
        if ({m_shk_wr_valid, m_shk_wr_msync, o_fifo_level, m_err_info, o_busy} !== {1'b0, 1'b0, 3'd0, 4'h0, 1'b0})
            $display("FAIL midreset_async: valid=%b msync=%b lvl=%0d err=%h busy=%b expected all 0",
                     m_shk_wr_valid, m_shk_wr_msync, o_fifo_level, m_err_info, o_busy);
        else n_pass++;
        tick();
        i_sys_resetn = 1'b1;
        rdy_auto = 1'b1;
        tick();
        push(8'h9A, 8'hBC);
        wait_issue(8'h9A, 8'hBC);
        repeat (3) tick();
        n_chk++;
        if (o_busy !== 1'b0 || o_fifo_level !== 3'd0)
            $display("FAIL midreset_dropped: busy=%b lvl=%0d expected 0, 0", o_busy, o_fifo_level);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] a, d;
        do_reset();
        rdy_auto = 1'b0;
        rdy_manual = 1'b0;
        tick();
        push(8'hA0, 8'hB0);
        push(8'hA1, 8'hB1);
        rdy_manual = 1'b1;
        push(8'hA2, 8'hB2);
        n_chk++;
        if (o_fifo_level !== 3'd2 || m_shk_wr_valid !== 1'b1 || m_shk_wr_maddr !== 8'hA0)
            $display("FAIL wrap_push_pop: lvl=%0d valid=%b maddr=%h expected 2, 1, A0", o_fifo_level, m_shk_wr_valid, m_shk_wr_maddr);
        else n_pass++;
        rdy_auto = 1'b1;
        push(8'hA3, 8'hB3);
        push(8'hA4, 8'hB4);
        n_chk++;
        if (o_fifo_level !== 3'd4 || s_cmd_ready !== 1'b0)
            $display("FAIL wrap_fill_during_addr: lvl=%0d rdy=%b expected 4, 0", o_fifo_level, s_cmd_ready);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            a = 8'hA0 + 8'(i);
            d = 8'hB0 + 8'(i);
            wait_issue(a, d);
        end
        for (int i = 5; i < 8; i++) begin
            a = 8'hA0 + 8'(i);
            d = 8'hB0 + 8'(i);
            push(a, d);
        end
        for (int i = 5; i < 8; i++) begin
            a = 8'hA0 + 8'(i);
            d = 8'hB0 + 8'(i);
            wait_issue(a, d);
        end
        n_chk++;
        if (o_fifo_level !== 3'd0 || m_err_info !== 4'h0)
            $display("FAIL wrap_end: lvl=%0d err=%h expected 0, 0", o_fifo_level, m_err_info);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_timeout();
        test_addr_err();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
